// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
//   cmp_state_e : controller state (IDLE, RUN, DONE)
//   RES_*       : one-hot result encoding, packed as {gt, eq, lt}
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Request/result bundle for seq_mag_comparator.
//   start, a, b, signed_mode : request side, driven by the master
//   busy, done, gt, eq, lt   : status/result side, driven by the comparator
//   state                    : comparator FSM state, for observation only
// Handshake: start is sampled only while the comparator is idle (busy=0 and
// done=0); a request is accepted on the rising edge where start=1 in IDLE.
// done is a single-cycle pulse; gt/eq/lt then hold until the next accepted
// start clears them. start while busy or done is dropped, never queued.
interface seq_mag_comparator_if #(
    parameter int WIDTH = 8
);
    import cmp_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    cmp_state_e       state;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, gt, eq, lt, state
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, gt, eq, lt, state
    );

endinterface

// File: rtl/chunk_cmp.sv
// Combinational DIGIT-bit magnitude comparator.
//   x, y     : chunk operands
//   flip_msb : invert both MSBs first (turns a two's-complement top chunk
//              into an order-preserving unsigned compare)
//   c_gt     : x > y
//   c_lt     : x < y
module chunk_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             flip_msb,
    output logic             c_gt,
    output logic             c_lt
);

    logic [DIGIT-1:0] msb_mask;
    logic [DIGIT-1:0] xa;
    logic [DIGIT-1:0] ya;

    always_comb begin
        msb_mask            = '0;
        msb_mask[DIGIT-1]   = flip_msb;
        xa                  = x ^ msb_mask;
        ya                  = y ^ msb_mask;
        c_gt                = (xa > ya);
        c_lt                = (xa < ya);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, DIGIT bits per cycle, MSB chunk
// first, stopping at the first unequal chunk. Supports unsigned and
// two's-complement compares.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/result bundle (slave side), see seq_mag_comparator_if
// The latched operands are shifted left one chunk per equal step, so the
// chunk under test always sits in the top DIGIT bits and a single chunk_cmp
// serves the whole width. idx counts chunks remaining and marks the top
// chunk (the only one that gets the sign adjustment).
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_mag_comparator_if.slave         bus
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic             c_gt;
    logic             c_lt;

    chunk_cmp #(.DIGIT(DIGIT)) u_chunk (
        .x        (a_q[WIDTH-1 -: DIGIT]),
        .y        (b_q[WIDTH-1 -: DIGIT]),
        .flip_msb (sgn_q && (idx_q == IDX_TOP)),
        .c_gt     (c_gt),
        .c_lt     (c_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sgn_d   = bus.signed_mode;
                    idx_d   = IDX_TOP;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (c_gt) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (c_lt) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    a_d     = a_q << DIGIT;
                    b_d     = b_q << DIGIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.gt    = gt_q;
    assign bus.eq    = eq_q;
    assign bus.lt    = lt_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: three instances (8/2, 2/1, 16/4) share one
// stimulus stream; each instance sees the low bits of the 16-bit operands.
// Index 0 = W2/D1, 1 = W8/D2, 2 = W16/D4.
module tb_seq_mag_comparator;
    import cmp_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        sgn_in;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    seq_mag_comparator_if #(.WIDTH(2))  bus2 ();
    seq_mag_comparator_if #(.WIDTH(8))  bus8 ();
    seq_mag_comparator_if #(.WIDTH(16)) bus16 ();

    assign bus2.start        = start;
    assign bus2.a            = a_in[1:0];
    assign bus2.b            = b_in[1:0];
    assign bus2.signed_mode  = sgn_in;
    assign bus8.start        = start;
    assign bus8.a            = a_in[7:0];
    assign bus8.b            = b_in[7:0];
    assign bus8.signed_mode  = sgn_in;
    assign bus16.start       = start;
    assign bus16.a           = a_in;
    assign bus16.b           = b_in;
    assign bus16.signed_mode = sgn_in;

    seq_mag_comparator #(.WIDTH(2),  .DIGIT(1)) u_w2  (.clk(clk), .rst(rst), .bus(bus2));
    seq_mag_comparator #(.WIDTH(8),  .DIGIT(2)) u_w8  (.clk(clk), .rst(rst), .bus(bus8));
    seq_mag_comparator #(.WIDTH(16), .DIGIT(4)) u_w16 (.clk(clk), .rst(rst), .bus(bus16));

    logic [2:0] done_v;
    logic [2:0] busy_v;
    logic [2:0] res_v [3];

    always_comb begin
        done_v   = {bus16.done, bus8.done, bus2.done};
        busy_v   = {bus16.busy, bus8.busy, bus2.busy};
        res_v[0] = {bus2.gt,  bus2.eq,  bus2.lt};
        res_v[1] = {bus8.gt,  bus8.eq,  bus8.lt};
        res_v[2] = {bus16.gt, bus16.eq, bus16.lt};
    end

    // ---------------- scoreboard helpers ----------------
    int         lat_r  [3];
    int         bcnt_r [3];
    int         dcnt_r [3];
    logic [2:0] res_r  [3];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected_range=[%0d,%0d]", name, act, lo, hi);
        end
    endtask

    function automatic logic [2:0] ref_res(input logic [15:0] av, input logic [15:0] bv,
                                           input int w, input logic sv);
        longint x, y, m;
        m = (longint'(1) << w) - 1;
        x = longint'(av) & m;
        y = longint'(bv) & m;
        if (sv) begin
            if (x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
            if (y >= (longint'(1) << (w - 1))) y -= (longint'(1) << w);
        end
        if (x > y)      return RES_GT;
        else if (x < y) return RES_LT;
        else            return RES_EQ;
    endfunction

    // ---------------- driver ----------------
    // Pulses start for one edge and watches all DUTs for a bounded window.
    // With inject set, a second start with different operands is driven
    // while the first compare is still running.
    task automatic run_cmp(input logic [15:0] av, input logic [15:0] bv,
                           input logic sv, input bit inject);
        for (int d = 0; d < 3; d++) begin
            lat_r[d] = 0; bcnt_r[d] = 0; dcnt_r[d] = 0; res_r[d] = 3'b000;
        end
        a_in = av; b_in = bv; sgn_in = sv; start = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) start = 1'b0;
            if (inject && cyc == 2) begin
                start = 1'b1; a_in = ~av; b_in = ~bv; sgn_in = ~sv;
            end
            if (inject && cyc == 3) start = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (busy_v[d]) bcnt_r[d]++;
                if (done_v[d]) begin
                    dcnt_r[d]++;
                    if (lat_r[d] == 0) begin
                        lat_r[d] = cyc;
                        res_r[d] = res_v[d];
                    end
                end
            end
        end
    endtask

    task automatic check_ref(input int d, input int w, input int nchunk, input string tag,
                             input logic [15:0] av, input logic [15:0] bv, input logic sv);
        chk({tag, "_res"}, res_r[d], ref_res(av, bv, w, sv));
        chk_rng({tag, "_lat"}, lat_r[d], 2, nchunk + 1);
        chk({tag, "_done_cnt"}, dcnt_r[d], 1);
    endtask

    // ---------------- directed table for the 8/2 instance ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic [2:0] res;
        int         lat;
        int         busy;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int seen;
        logic [15:0] ra, rb;
        logic rs;

        tbl[0] = '{8'hA5, 8'h5A, 1'b0, RES_GT, 2, 1};
        tbl[1] = '{8'hA5, 8'h5A, 1'b1, RES_LT, 2, 1};
        tbl[2] = '{8'h3C, 8'h3C, 1'b0, RES_EQ, 5, 4};
        tbl[3] = '{8'h81, 8'h80, 1'b0, RES_GT, 5, 4};
        tbl[4] = '{8'h80, 8'h7F, 1'b1, RES_LT, 2, 1};
        tbl[5] = '{8'h80, 8'h7F, 1'b0, RES_GT, 2, 1};
        tbl[6] = '{8'hFF, 8'hFE, 1'b1, RES_GT, 5, 4};
        tbl[7] = '{8'h12, 8'h13, 1'b0, RES_LT, 5, 4};
        tbl[8] = '{8'h00, 8'h00, 1'b1, RES_EQ, 5, 4};
        tbl[9] = '{8'h34, 8'h24, 1'b0, RES_GT, 3, 2};

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; sgn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt}, 0);
        chk("reset_state", bus8.state, IDLE);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_cmp({8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].sgn, 1'b0);
            chk($sformatf("v%0d_res", i), res_r[1], tbl[i].res);
            chk($sformatf("v%0d_lat", i), lat_r[1], tbl[i].lat);
            chk($sformatf("v%0d_busy", i), bcnt_r[1], tbl[i].busy);
            chk($sformatf("v%0d_done_cnt", i), dcnt_r[1], 1);
            chk($sformatf("v%0d_hold", i), {bus8.gt, bus8.eq, bus8.lt}, tbl[i].res);
        end

        // start + new operands mid-RUN are ignored
        run_cmp(16'h0081, 16'h0080, 1'b0, 1'b1);
        chk("inject_res", res_r[1], RES_GT);
        chk("inject_lat", lat_r[1], 5);
        chk("inject_busy", bcnt_r[1], 4);
        chk("inject_done_cnt", dcnt_r[1], 1);

        // reset during the 2nd RUN cycle of an equal compare
        a_in = 16'h003C; b_in = 16'h003C; sgn_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", bus8.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus8.done) seen++;
        end
        chk("no_done_after_rst", seen, 0);
        run_cmp(16'h003C, 16'h003C, 1'b0, 1'b0);
        chk("post_rst_res", res_r[1], RES_EQ);
        chk("post_rst_lat", lat_r[1], 5);

        // exhaustive 2-bit operands in both modes; upper bits vary for the others
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 4; x++) begin
                for (int y = 0; y < 4; y++) begin
                    ra = {16'($urandom_range(0, 16'h3FFF)), 2'b00} | 16'(x);
                    rb = {16'($urandom_range(0, 16'h3FFF)), 2'b00} | 16'(y);
                    rs = s[0];
                    run_cmp(ra, rb, rs, 1'b0);
                    check_ref(0, 2, 2, $sformatf("w2_s%0d_%0d_%0d", s, x, y), ra, rb, rs);
                end
            end
        end

        // random 16-bit pairs; small pools of shared upper bits make equal
        // prefixes common so later chunks get exercised
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom_range(0, 16'hFFFF));
            rb = 16'($urandom_range(0, 16'hFFFF));
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = {ra[15:4], rb[3:0]};
                2: rb = {ra[15:8], rb[7:0]};
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_cmp(ra, rb, rs, 1'b0);
            check_ref(2, 16, 4, $sformatf("w16_r%0d", n), ra, rb, rs);
            check_ref(1, 8, 4, $sformatf("w8_r%0d", n), ra, rb, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
Parametrised multi-cycle magnitude comparator. It generalises the team's 2-bit combinational comparator to WIDTH-bit operands. Operands are compared DIGIT bits per cycle, MSB chunk first, with early termination on the first unequal chunk. Signed and unsigned modes are supported. A start/busy/done handshake lets it sit behind a controller or datapath sequencer and share one small chunk comparator across the whole width.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of DIGIT.
DIGIT, 2, bits compared per cycle; 1 <= DIGIT <= WIDTH.
NCHUNK, WIDTH/DIGIT, derived local constant, not overridable.

Ports:
clk  input  1  single clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request a comparison; sampled only in IDLE
a  input  WIDTH  operand A; captured on start acceptance
b  input  WIDTH  operand B; captured on start acceptance
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with operands
busy  output  1  high while the FSM is in RUN
done  output  1  one-cycle pulse; result is valid
gt  output  1  A > B
eq  output  1  A == B
lt  output  1  A < B

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset state:
  - FSM = IDLE.
  - busy = done = gt = eq = lt = 0.
  - Operand registers and chunk index = 0.
- IDLE:
  - If start = 1 at edge E0: latch a, b and signed_mode; set idx = NCHUNK-1; clear gt/eq/lt to 0; go to RUN.
  - If start = 0: stay in IDLE.
- RUN (busy = 1):
  - Each edge compares chunk idx, i.e. bits [idx*DIGIT+DIGIT-1 : idx*DIGIT], of the latched A and B.
  - Signed mode: for the top chunk only, the operand MSBs are inverted before comparison. All other chunks are compared unsigned.
  - Chunk A > chunk B: set gt = 1, go to DONE.
  - Chunk A < chunk B: set lt = 1, go to DONE.
  - Chunks equal and idx == 0: set eq = 1, go to DONE.
  - Chunks equal and idx > 0: decrement idx, stay in RUN.
- DONE: done = 1 for exactly one cycle, busy = 0, then return to IDLE unconditionally.
- Exactly one of gt/eq/lt is 1 after any completed compare.
- Latency: start accepted at E0, decision registered at edge Ek (1 <= k <= NCHUNK), done high during the cycle after Ek. Worst case: done in cycle NCHUNK+1 after start.
- Result hold: gt/eq/lt keep their value after done until the next start is accepted, which clears them.
- start during RUN or DONE: ignored, not queued.
- Operand changes on a/b after acceptance have no effect.
- Reset asserted mid-RUN: immediate return to reset state. The in-flight compare is aborted and done is never raised for it.
- Back-to-back: start held high continuously restarts the compare on the first IDLE cycle after each DONE.
- WIDTH = DIGIT degenerate case: a single RUN cycle; the signed adjustment applies to that chunk.

Decomposition:
- Package cmp_pkg:
  - FSM state enum {IDLE, RUN, DONE}.
  - Result encoding constants RES_GT / RES_EQ / RES_LT, used by the bench scoreboard.
- Sub-module chunk_cmp: purely combinational DIGIT-bit comparator.
  - Inputs: x, y, flip_msb.
  - Outputs: c_gt, c_lt.
  - Instantiated once; the top level contains the FSM, operand registers, index counter and result registers.

Test Plan:
1. WIDTH=8, DIGIT=2, unsigned. a=8'hA5, b=8'h5A, start pulse -> gt=1, eq=lt=0; done high exactly 2 cycles after the start edge (top chunk decides).
2. Same operands, signed_mode=1 -> lt=1 (-91 < 90); same 2-cycle latency.
3. a=b=8'h3C -> eq=1 after all 4 chunks; done in cycle 5 after start; busy high for 4 cycles.
4. a=8'h81, b=8'h80 -> gt=1, decided at chunk 0; busy held 4 cycles. A start pulse plus new operands driven mid-RUN -> ignored, result still gt.
5. Assert rst in the 2nd RUN cycle of an eq compare -> busy/done/gt/eq/lt all 0 immediately; no done pulse follows. A new start after reset release completes normally.
6. WIDTH=2, DIGIT=1, exhaustive over all 16 (a,b) pairs in both modes, plus WIDTH=16, DIGIT=4 with 1000 random pairs -> gt/eq/lt match a behavioural reference, exactly one flag set, latency in range [2, NCHUNK+1].
